// File: rtl/fpu_div_arbiter.sv
// Round-robin arbiter sharing one multi-cycle divider between NUM_REQ FPU
// clients. A granted request is latched, the divider is launched with a
// one-cycle start pulse, and the quotient (or a timeout error) is returned
// to the owner over a valid/ready handshake. Operands are opaque bit vectors.
module fpu_div_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 64,
  parameter int TIMEOUT = 255,
  parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_err,
  output logic                     div_start,
  output logic [WIDTH-1:0]         div_a,
  output logic [WIDTH-1:0]         div_b,
  input  logic [WIDTH-1:0]         div_result,
  input  logic                     div_done,
  output logic                     busy,
  output logic [IDW-1:0]           grant_id
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] div_a_q, div_a_d;
  logic [WIDTH-1:0] div_b_q, div_b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             err_q, err_d;
  logic             busy_q;
  logic             win_vld;
  logic [IDW-1:0]   win_id;

  // Round-robin search: first valid client after the last completed owner.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!win_vld && req_valid[(int'(last_q) + i) % NUM_REQ]) begin
        win_vld = 1'b1;
        win_id  = IDW'((int'(last_q) + i) % NUM_REQ);
      end
    end
  end

  // Handshake strobes decoded from the state register.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state_q == S_IDLE && win_vld) req_ready[win_id]  = 1'b1;
    if (state_q == S_RESP)            rsp_valid[grant_q] = 1'b1;
  end

  assign div_start  = (state_q == S_ISSUE);
  assign div_a      = div_a_q;
  assign div_b      = div_b_q;
  assign rsp_result = res_q;
  assign rsp_err    = err_q;
  assign busy       = busy_q;
  assign grant_id   = grant_q;

  // Next-state logic for the transaction sequencer and its datapath latches.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    div_a_d = div_a_q;
    div_b_d = div_b_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          div_a_d = req_a[int'(win_id)*WIDTH +: WIDTH];
          div_b_d = req_b[int'(win_id)*WIDTH +: WIDTH];
          grant_d = win_id;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done in the final watchdog cycle still counts as success.
        if (div_done) begin
          res_d   = div_result;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        // Pointer only advances on completion, which keeps grants fair.
        if (rsp_ready[grant_q]) begin
          last_d  = grant_q;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= IDW'(NUM_REQ - 1);
      grant_q <= '0;
      cnt_q   <= '0;
      div_a_q <= '0;
      div_b_q <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      div_a_q <= div_a_d;
      div_b_q <= div_b_d;
      res_q   <= res_d;
      err_q   <= err_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

endmodule
